// File: rtl/ball_motion_ctrl.sv
// Per-ball kinematics: accepts a cue shot, then on each frame reflects,
// applies friction and integrates a fixed-point position until the ball rests.
module ball_motion_ctrl #(
  parameter int INITIAL_X = 280,
  parameter int INITIAL_Y = 185,
  parameter int FRAC_BITS = 6,
  parameter int FRICTION  = 1,
  parameter int MAX_SPEED = 640,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               SingleHitPulse,
  input  logic [1:0]         hit_axis,
  input  logic               shot_valid,
  input  logic signed [10:0] shot_vx,
  input  logic signed [10:0] shot_vy,
  output logic               shot_ready,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic signed [10:0] ball_vx,
  output logic signed [10:0] ball_vy,
  output logic               ball_moving,
  output logic               ball_stopped_pulse
);

  localparam logic [16:0]        X_INIT = 17'(INITIAL_X << FRAC_BITS);
  localparam logic [16:0]        Y_INIT = 17'(INITIAL_Y << FRAC_BITS);
  localparam logic [16:0]        X_LIM  = 17'((SCREEN_W - 1) << FRAC_BITS);
  localparam logic [16:0]        Y_LIM  = 17'((SCREEN_H - 1) << FRAC_BITS);
  localparam logic signed [11:0] V_MAX  = 12'(MAX_SPEED);
  localparam logic signed [11:0] V_FRIC = 12'(FRICTION);

  typedef enum logic {REST, ROLLING} state_e;

  state_e              state_q;
  logic [1:0]          pend_q;
  logic [16:0]         posx_q, posy_q;
  logic signed [10:0]  vx_q, vy_q;
  logic signed [10:0]  tlx_q, tly_q;
  logic                ready_q, moving_q, stopped_q;

  logic [1:0]          pend_eff;
  logic signed [10:0]  vx_d, vy_d;
  logic [16:0]         posx_d, posy_d;

  function automatic logic signed [10:0] clamp_shot(input logic signed [10:0] v);
    logic signed [11:0] w;
    w = {v[10], v};
    if (w > V_MAX)       w = V_MAX;
    else if (w < -V_MAX) w = -V_MAX;
    return w[10:0];
  endfunction

  // Reflect, then shrink magnitude toward zero without crossing it.
  function automatic logic signed [10:0] step_vel(input logic signed [10:0] v,
                                                  input logic               flip);
    logic signed [11:0] w;
    w = {v[10], v};
    if (flip) w = -w;
    if (w > V_FRIC)       w = w - V_FRIC;
    else if (w < -V_FRIC) w = w + V_FRIC;
    else                  w = '0;
    if (w > 12'sd1023)       w = 12'sd1023;
    else if (w < -12'sd1024) w = -12'sd1024;
    return w[10:0];
  endfunction

  function automatic logic [16:0] step_pos(input logic [16:0]        p,
                                           input logic signed [10:0] v,
                                           input logic [16:0]        lim);
    logic signed [18:0] s;
    s = $signed({2'b00, p}) + $signed({{8{v[10]}}, v});
    if (s < 19'sd0)                   return '0;
    else if (s > $signed({2'b00, lim})) return lim;
    return s[16:0];
  endfunction

  always_comb begin
    pend_eff = pend_q | (SingleHitPulse ? hit_axis : 2'b00);
    vx_d     = step_vel(vx_q, pend_eff[0]);
    vy_d     = step_vel(vy_q, pend_eff[1]);
    posx_d   = step_pos(posx_q, vx_d, X_LIM);
    posy_d   = step_pos(posy_q, vy_d, Y_LIM);
  end

  // NOTE: reset is synchronous and active-high here; every register, flags
  // included, uses non-blocking assignment so all see pre-edge values.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q   <= REST;
      pend_q    <= '0;
      posx_q    <= X_INIT;
      posy_q    <= Y_INIT;
      tlx_q     <= 11'(INITIAL_X);
      tly_q     <= 11'(INITIAL_Y);
      vx_q      <= '0;
      vy_q      <= '0;
      ready_q   <= 1'b1;
      moving_q  <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      stopped_q <= 1'b0;
      unique case (state_q)
        REST: begin
          if (shot_valid) begin
            vx_q     <= clamp_shot(shot_vx);
            vy_q     <= clamp_shot(shot_vy);
            state_q  <= ROLLING;
            ready_q  <= 1'b0;
            moving_q <= 1'b1;
          end
        end
        ROLLING: begin
          if (startOfFrame) begin
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            posx_q <= posx_d;
            posy_q <= posy_d;
            tlx_q  <= 11'(posx_d >> FRAC_BITS);
            tly_q  <= 11'(posy_d >> FRAC_BITS);
            pend_q <= '0;
            if (vx_d == 11'sd0 && vy_d == 11'sd0) begin
              state_q   <= REST;
              ready_q   <= 1'b1;
              moving_q  <= 1'b0;
              stopped_q <= 1'b1;
            end
          end else if (SingleHitPulse) begin
            pend_q <= pend_q | hit_axis;
          end
        end
        default: state_q <= REST;
      endcase
    end
  end

  assign shot_ready         = ready_q;
  assign ball_moving        = moving_q;
  assign ball_stopped_pulse = stopped_q;
  assign ball_vx            = vx_q;
  assign ball_vy            = vy_q;
  assign topLeftX           = tlx_q;
  assign topLeftY           = tly_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed scenarios plus randomized traffic
// checked against an integer-arithmetic model of the ball's motion.
module tb_ball_motion_ctrl;

  localparam int IX = 280, IY = 185, FB = 6, FR = 1, MS = 640, SW = 640, SH = 480;

  logic               clk = 1'b0;
  logic               resetN = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               SingleHitPulse = 1'b0;
  logic [1:0]         hit_axis = 2'b00;
  logic               shot_valid = 1'b0;
  logic signed [10:0] shot_vx = '0, shot_vy = '0;
  logic               shot_ready, ball_moving, ball_stopped_pulse;
  logic signed [10:0] topLeftX, topLeftY, ball_vx, ball_vy;

  int vectors = 0;
  int miscompares = 0;

  bit       m_roll, m_stop;
  int       m_vx, m_vy, m_px, m_py;
  bit [1:0] m_pend;

  ball_motion_ctrl #(
    .INITIAL_X(IX), .INITIAL_Y(IY), .FRAC_BITS(FB), .FRICTION(FR),
    .MAX_SPEED(MS), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .SingleHitPulse(SingleHitPulse), .hit_axis(hit_axis),
    .shot_valid(shot_valid), .shot_vx(shot_vx), .shot_vy(shot_vy),
    .shot_ready(shot_ready), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .ball_vx(ball_vx), .ball_vy(ball_vy), .ball_moving(ball_moving),
    .ball_stopped_pulse(ball_stopped_pulse)
  );

  always #5 clk = ~clk;

  function automatic int clamp_i(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int slow_down(int v);
    int mag;
    mag = (v < 0) ? -v : v;
    mag = (mag > FR) ? mag - FR : 0;
    return (v < 0) ? -mag : mag;
  endfunction

  // Advance one clock: the model consumes the inputs present at the edge,
  // then one-cycle strobes are dropped.
  task automatic tick();
    bit [1:0] ep;
    @(posedge clk);
    m_stop = 1'b0;
    if (resetN) begin
      m_roll = 1'b0; m_pend = 2'b00; m_vx = 0; m_vy = 0;
      m_px = IX << FB; m_py = IY << FB;
    end else if (!m_roll) begin
      if (shot_valid) begin
        m_vx = clamp_i(int'(shot_vx), -MS, MS);
        m_vy = clamp_i(int'(shot_vy), -MS, MS);
        m_roll = 1'b1;
      end
    end else if (startOfFrame) begin
      ep = m_pend | (SingleHitPulse ? hit_axis : 2'b00);
      m_vx = slow_down(ep[0] ? -m_vx : m_vx);
      m_vy = slow_down(ep[1] ? -m_vy : m_vy);
      m_px = clamp_i(m_px + m_vx, 0, (SW - 1) << FB);
      m_py = clamp_i(m_py + m_vy, 0, (SH - 1) << FB);
      m_pend = 2'b00;
      if (m_vx == 0 && m_vy == 0) begin
        m_roll = 1'b0;
        m_stop = 1'b1;
      end
    end else if (SingleHitPulse) begin
      m_pend = m_pend | hit_axis;
    end
    #1;
    resetN = 1'b0; startOfFrame = 1'b0; SingleHitPulse = 1'b0; shot_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    tick();
  endtask

  task automatic fire(input int vx, input int vy);
    shot_valid = 1'b1; shot_vx = 11'(vx); shot_vy = 11'(vy);
    tick();
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (topLeftX !== 11'sd280 || topLeftY !== 11'sd185) begin
      miscompares++;
      $display("FAIL reset_pos got (%0d,%0d) want (280,185)", topLeftX, topLeftY);
    end
    vectors++;
    if (ball_vx !== 11'sd0 || ball_vy !== 11'sd0) begin
      miscompares++;
      $display("FAIL reset_vel got (%0d,%0d) want (0,0)", ball_vx, ball_vy);
    end
    vectors++;
    if (shot_ready !== 1'b1 || ball_moving !== 1'b0 || ball_stopped_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got ready=%b moving=%b stop=%b want 1 0 0",
               shot_ready, ball_moving, ball_stopped_pulse);
    end
  endtask

  task automatic test_shot_frame();
    do_reset();
    fire(130, 0);
    vectors++;
    if (shot_ready !== 1'b0 || ball_moving !== 1'b1 || ball_vx !== 11'sd130 || topLeftX !== 11'sd280) begin
      miscompares++;
      $display("FAIL shot_accept got ready=%b moving=%b vx=%0d x=%0d want 0 1 130 280",
               shot_ready, ball_moving, ball_vx, topLeftX);
    end
    frame();
    vectors++;
    if (ball_vx !== 11'sd129 || topLeftX !== 11'sd282 || topLeftY !== 11'sd185) begin
      miscompares++;
      $display("FAIL first_frame got vx=%0d pos=(%0d,%0d) want 129 (282,185)",
               ball_vx, topLeftX, topLeftY);
    end
  endtask

  task automatic test_reflect();
    do_reset();
    fire(130, -65);
    startOfFrame = 1'b1; SingleHitPulse = 1'b1; hit_axis = 2'b01;
    tick();
    vectors++;
    if (ball_vx !== -11'sd129 || ball_vy !== -11'sd64) begin
      miscompares++;
      $display("FAIL reflect_same_cycle got (%0d,%0d) want (-129,-64)", ball_vx, ball_vy);
    end
    frame();
    vectors++;
    if (ball_vx !== -11'sd128 || ball_vy !== -11'sd63) begin
      miscompares++;
      $display("FAIL no_hit_frame got (%0d,%0d) want (-128,-63)", ball_vx, ball_vy);
    end
    for (int i = 0; i < 2; i++) begin
      SingleHitPulse = 1'b1; hit_axis = 2'b10;
      tick();
    end
    frame();
    vectors++;
    if (ball_vx !== -11'sd127 || ball_vy !== 11'sd62) begin
      miscompares++;
      $display("FAIL double_hit got (%0d,%0d) want (-127,62)", ball_vx, ball_vy);
    end
  endtask

  task automatic test_stop();
    do_reset();
    fire(3, 0);
    frame();
    frame();
    vectors++;
    if (ball_vx !== 11'sd1 || ball_moving !== 1'b1 || ball_stopped_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_pre got vx=%0d moving=%b stop=%b want 1 1 0",
               ball_vx, ball_moving, ball_stopped_pulse);
    end
    SingleHitPulse = 1'b1; hit_axis = 2'b11;
    frame();
    vectors++;
    if (ball_vx !== 11'sd0 || ball_stopped_pulse !== 1'b1 || shot_ready !== 1'b1 || ball_moving !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_edge got vx=%0d stop=%b ready=%b moving=%b want 0 1 1 0",
               ball_vx, ball_stopped_pulse, shot_ready, ball_moving);
    end
    tick();
    vectors++;
    if (ball_stopped_pulse !== 1'b0 || topLeftX !== 11'sd280) begin
      miscompares++;
      $display("FAIL stop_after got stop=%b x=%0d want 0 280", ball_stopped_pulse, topLeftX);
    end
    startOfFrame = 1'b1;
    fire(50, -7);
    vectors++;
    if (ball_vx !== 11'sd50 || ball_vy !== -11'sd7) begin
      miscompares++;
      $display("FAIL shot_with_frame got (%0d,%0d) want (50,-7)", ball_vx, ball_vy);
    end
    do_reset();
    fire(0, 0);
    vectors++;
    if (ball_moving !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_shot_accept got moving=%b want 1", ball_moving);
    end
    frame();
    vectors++;
    if (ball_moving !== 1'b0 || ball_stopped_pulse !== 1'b1 || shot_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_shot_stop got moving=%b stop=%b ready=%b want 0 1 1",
               ball_moving, ball_stopped_pulse, shot_ready);
    end
  endtask

  task automatic test_saturation();
    logic signed [10:0] prev_x;
    bit wrapped;
    do_reset();
    fire(1000, -1000);
    vectors++;
    if (ball_vx !== 11'sd640 || ball_vy !== -11'sd640) begin
      miscompares++;
      $display("FAIL shot_clamp got (%0d,%0d) want (640,-640)", ball_vx, ball_vy);
    end
    fire(5, 5);
    vectors++;
    if (ball_vx !== 11'sd640 || ball_vy !== -11'sd640) begin
      miscompares++;
      $display("FAIL shot_ignored got (%0d,%0d) want (640,-640)", ball_vx, ball_vy);
    end
    wrapped = 1'b0;
    prev_x = topLeftX;
    for (int i = 0; i < 60; i++) begin
      frame();
      if (topLeftX < prev_x) wrapped = 1'b1;
      prev_x = topLeftX;
    end
    vectors++;
    if (wrapped || topLeftX !== 11'sd639 || topLeftY !== 11'sd0) begin
      miscompares++;
      $display("FAIL edge_clamp got wrapped=%b pos=(%0d,%0d) want 0 (639,0)",
               wrapped, topLeftX, topLeftY);
    end
    vectors++;
    if (ball_vx !== 11'sd580 || ball_moving !== 1'b1) begin
      miscompares++;
      $display("FAIL long_roll got vx=%0d moving=%b want 580 1", ball_vx, ball_moving);
    end
    do_reset();
    vectors++;
    if (topLeftX !== 11'sd280 || topLeftY !== 11'sd185 || ball_vx !== 11'sd0 ||
        ball_vy !== 11'sd0 || shot_ready !== 1'b1 || ball_moving !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_roll_reset got pos=(%0d,%0d) v=(%0d,%0d) ready=%b moving=%b",
               topLeftX, topLeftY, ball_vx, ball_vy, shot_ready, ball_moving);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      startOfFrame   = ($urandom_range(0, 1) == 0);
      SingleHitPulse = ($urandom_range(0, 5) == 0);
      hit_axis       = 2'($urandom_range(0, 3));
      shot_valid     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        shot_vx = 11'($urandom_range(0, 80)) - 11'sd40;
        shot_vy = 11'($urandom_range(0, 80)) - 11'sd40;
      end else begin
        shot_vx = 11'($urandom);
        shot_vy = 11'($urandom);
      end
      resetN = ($urandom_range(0, 499) == 0);
      tick();
      vectors++;
      if (topLeftX !== 11'(m_px >> FB) || topLeftY !== 11'(m_py >> FB)) begin
        miscompares++;
        $display("FAIL rand_pos cyc %0d got (%0d,%0d) want (%0d,%0d)",
                 n, topLeftX, topLeftY, m_px >> FB, m_py >> FB);
      end
      vectors++;
      if (ball_vx !== 11'(m_vx) || ball_vy !== 11'(m_vy)) begin
        miscompares++;
        $display("FAIL rand_vel cyc %0d got (%0d,%0d) want (%0d,%0d)",
                 n, ball_vx, ball_vy, m_vx, m_vy);
      end
      vectors++;
      if (shot_ready !== !m_roll || ball_moving !== m_roll || ball_stopped_pulse !== m_stop) begin
        miscompares++;
        $display("FAIL rand_flags cyc %0d got ready=%b moving=%b stop=%b want %b %b %b",
                 n, shot_ready, ball_moving, ball_stopped_pulse, !m_roll, m_roll, m_stop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shot_frame();
    test_reflect();
    test_stop();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
